// File: rtl/grf_wb_pkg.sv
// rtl/grf_wb_pkg.sv - shared types for GRF writeback arbitration
package grf_wb_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    SRC_PIPE = 1'b0,
    SRC_MDU  = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
  } wb_req;

  function automatic logic [31:0] reg_onehot(input logic [4:0] wa);
    reg_onehot = 32'd1 << wa;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of MDU writeback requests with per-entry taps
module wb_fifo
  import grf_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_req                 push_data,
  input  logic                  pop,
  output wb_req                 head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [DEPTH-1:0][4:0] entry_wa
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  wb_req         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    entry_valid = '0;
    entry_wa    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_wa[i]    = mem[i].wa;
      entry_valid[i] = ({1'b0, PW'(i) - rd_ptr} < count);
    end
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// rtl/grf_wb_arbiter.sv - arbitrates the GRF write port between pipeline WB and the MDU
module grf_wb_arbiter
  import grf_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid,
  output logic        pipe_ready,
  input  logic [4:0]  pipe_wa,
  input  logic [31:0] pipe_wd,
  input  logic [31:0] pipe_pc,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_wa,
  input  logic [31:0] mdu_wd,
  input  logic [31:0] mdu_pc,
  output logic        grf_we,
  output logic [4:0]  grf_wa,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc,
  output logic [31:0] mdu_busy_mask
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

  logic                       fifo_full;
  logic                       fifo_empty;
  wb_req                      fifo_head;
  wb_req                      mdu_req;
  logic [FIFO_DEPTH-1:0]      ent_valid;
  logic [FIFO_DEPTH-1:0][4:0] ent_wa;
  logic                       sel_mdu;
  logic [CW-1:0]              starve_cnt;
  wb_src_e                    out_src;

  assign mdu_req    = '{wa: mdu_wa, wd: mdu_wd, pc: mdu_pc};
  assign mdu_ready  = !fifo_full;
  assign sel_mdu    = !fifo_empty && (!pipe_valid || starve_cnt >= WAIT_LIM);
  assign pipe_ready = !sel_mdu;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (mdu_valid),
    .push_data   (mdu_req),
    .pop         (sel_mdu),
    .head        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_valid (ent_valid),
    .entry_wa    (ent_wa)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (fifo_empty || sel_mdu) begin
      starve_cnt <= '0;
    end else if (pipe_valid && starve_cnt < WAIT_LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // $0 writes still move through the stage so the handshake completes, but never assert WE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grf_we  <= 1'b0;
      grf_wa  <= '0;
      grf_wd  <= '0;
      grf_pc  <= '0;
      out_src <= SRC_PIPE;
    end else if (sel_mdu) begin
      grf_we  <= (fifo_head.wa != REG_ZERO);
      grf_wa  <= fifo_head.wa;
      grf_wd  <= fifo_head.wd;
      grf_pc  <= fifo_head.pc;
      out_src <= SRC_MDU;
    end else if (pipe_valid) begin
      grf_we  <= (pipe_wa != REG_ZERO);
      grf_wa  <= pipe_wa;
      grf_wd  <= pipe_wd;
      grf_pc  <= pipe_pc;
      out_src <= SRC_PIPE;
    end else begin
      grf_we  <= 1'b0;
    end
  end

  always_comb begin
    mdu_busy_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i]) mdu_busy_mask = mdu_busy_mask | reg_onehot(ent_wa[i]);
    end
    if (grf_we && out_src == SRC_MDU) mdu_busy_mask = mdu_busy_mask | reg_onehot(grf_wa);
    mdu_busy_mask = mdu_busy_mask & ~reg_onehot(REG_ZERO);
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb/tb_grf_wb_arbiter.sv - directed self-checking bench for grf_wb_arbiter
module tb_grf_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        pipe_valid;
  logic        pipe_ready;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic [31:0] pipe_pc;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_wa;
  logic [31:0] mdu_wd;
  logic [31:0] mdu_pc;
  logic        grf_we;
  logic [4:0]  grf_wa;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic [31:0] mdu_busy_mask;

  int total;
  int bad;

  grf_wb_arbiter #(.FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .pipe_valid    (pipe_valid),
    .pipe_ready    (pipe_ready),
    .pipe_wa       (pipe_wa),
    .pipe_wd       (pipe_wd),
    .pipe_pc       (pipe_pc),
    .mdu_valid     (mdu_valid),
    .mdu_ready     (mdu_ready),
    .mdu_wa        (mdu_wa),
    .mdu_wd        (mdu_wd),
    .mdu_pc        (mdu_pc),
    .grf_we        (grf_we),
    .grf_wa        (grf_wa),
    .grf_wd        (grf_wd),
    .grf_pc        (grf_pc),
    .mdu_busy_mask (mdu_busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pipe_valid = 1'b0; pipe_wa = '0; pipe_wd = '0; pipe_pc = '0;
    mdu_valid = 1'b0;  mdu_wa = '0;  mdu_wd = '0;  mdu_pc = '0;
    tick();
    tick();
    total++; if (pipe_ready !== 1'b1) begin bad++; $display("FAIL rst_pipe_ready_in_reset got=%b exp=1", pipe_ready); end
    total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL rst_mdu_ready_in_reset got=%b exp=1", mdu_ready); end
    #3 reset = 1'b1;
    tick();
    tick();
    total++; if (grf_we !== 1'b0) begin bad++; $display("FAIL rst_grf_we got=%b exp=0", grf_we); end
    total++; if (mdu_busy_mask !== 32'h0) begin bad++; $display("FAIL rst_mask got=%h exp=0", mdu_busy_mask); end
    total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL rst_mdu_ready got=%b exp=1", mdu_ready); end
    total++; if (pipe_ready !== 1'b1) begin bad++; $display("FAIL rst_pipe_ready got=%b exp=1", pipe_ready); end
  endtask

  task automatic test_pipe_write();
    pipe_valid = 1'b1; pipe_wa = 5'd3; pipe_wd = 32'h1234; pipe_pc = 32'h3000;
    total++; if (pipe_ready !== 1'b1) begin bad++; $display("FAIL pipe_ready got=%b exp=1", pipe_ready); end
    tick();
    pipe_valid = 1'b0;
    total++; if ({grf_we, grf_wa} !== {1'b1, 5'd3}) begin bad++; $display("FAIL pipe_we_wa got=%b/%0d exp=1/3", grf_we, grf_wa); end
    total++; if (grf_wd !== 32'h1234) begin bad++; $display("FAIL pipe_wd got=%h exp=1234", grf_wd); end
    total++; if (grf_pc !== 32'h3000) begin bad++; $display("FAIL pipe_pc got=%h exp=3000", grf_pc); end
    total++; if (mdu_busy_mask !== 32'h0) begin bad++; $display("FAIL pipe_mask got=%h exp=0", mdu_busy_mask); end
    tick();
    total++; if (grf_we !== 1'b0) begin bad++; $display("FAIL pipe_we_idle got=%b exp=0", grf_we); end
  endtask

  task automatic test_mdu_single();
    mdu_valid = 1'b1; mdu_wa = 5'd8; mdu_wd = 32'hBEEF; mdu_pc = 32'h4000;
    total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL mdu1_ready got=%b exp=1", mdu_ready); end
    tick();
    mdu_valid = 1'b0;
    total++; if (mdu_busy_mask !== 32'h0000_0100) begin bad++; $display("FAIL mdu1_mask_fifo got=%h exp=00000100", mdu_busy_mask); end
    total++; if (grf_we !== 1'b0) begin bad++; $display("FAIL mdu1_we_early got=%b exp=0", grf_we); end
    tick();
    total++; if ({grf_we, grf_wa} !== {1'b1, 5'd8}) begin bad++; $display("FAIL mdu1_we_wa got=%b/%0d exp=1/8", grf_we, grf_wa); end
    total++; if (grf_wd !== 32'hBEEF || grf_pc !== 32'h4000) begin bad++; $display("FAIL mdu1_wd_pc got=%h/%h exp=beef/4000", grf_wd, grf_pc); end
    total++; if (mdu_busy_mask !== 32'h0000_0100) begin bad++; $display("FAIL mdu1_mask_out got=%h exp=00000100", mdu_busy_mask); end
    tick();
    total++; if (mdu_busy_mask !== 32'h0) begin bad++; $display("FAIL mdu1_mask_clear got=%h exp=0", mdu_busy_mask); end
    total++; if (grf_we !== 1'b0) begin bad++; $display("FAIL mdu1_we_clear got=%b exp=0", grf_we); end
  endtask

  task automatic test_starvation();
    pipe_valid = 1'b1; pipe_wa = 5'd4; pipe_wd = 32'h100; pipe_pc = 32'h5000;
    mdu_valid = 1'b1;  mdu_wa = 5'd9;  mdu_wd = 32'h55;   mdu_pc = 32'h6000;
    total++; if (pipe_ready !== 1'b1) begin bad++; $display("FAIL starve_first_ready got=%b exp=1", pipe_ready); end
    tick();
    mdu_valid = 1'b0;
    total++; if (grf_wd !== 32'h100) begin bad++; $display("FAIL starve_first_wd got=%h exp=100", grf_wd); end
    total++; if (mdu_busy_mask !== 32'h0000_0200) begin bad++; $display("FAIL starve_mask got=%h exp=00000200", mdu_busy_mask); end
    for (int k = 0; k < 4; k++) begin
      pipe_wd = 32'h101 + k;
      total++; if (pipe_ready !== 1'b1) begin bad++; $display("FAIL starve_ready_%0d got=%b exp=1", k, pipe_ready); end
      tick();
      total++; if (grf_wd !== 32'h101 + k) begin bad++; $display("FAIL starve_pipe_wd_%0d got=%h exp=%h", k, grf_wd, 32'h101 + k); end
    end
    pipe_wd = 32'h105;
    total++; if (pipe_ready !== 1'b0) begin bad++; $display("FAIL starve_stall got=%b exp=0", pipe_ready); end
    tick();
    total++; if ({grf_we, grf_wa, grf_wd} !== {1'b1, 5'd9, 32'h55}) begin bad++; $display("FAIL starve_mdu_grant got=%b/%0d/%h exp=1/9/55", grf_we, grf_wa, grf_wd); end
    total++; if (pipe_ready !== 1'b1) begin bad++; $display("FAIL starve_ready_after got=%b exp=1", pipe_ready); end
    tick();
    pipe_valid = 1'b0;
    total++; if ({grf_wa, grf_wd} !== {5'd4, 32'h105}) begin bad++; $display("FAIL starve_held_pipe got=%0d/%h exp=4/105", grf_wa, grf_wd); end
    total++; if (mdu_busy_mask !== 32'h0) begin bad++; $display("FAIL starve_mask_clear got=%h exp=0", mdu_busy_mask); end
    tick();
  endtask

  task automatic test_fifo_full();
    logic [31:0] seen[$];
    int          accept_at;
    logic        accepted;
    accept_at = -1;
    pipe_valid = 1'b1; pipe_wa = 5'd5; pipe_wd = 32'h200; pipe_pc = 32'h7000;
    mdu_valid = 1'b1;  mdu_wa = 5'd10; mdu_wd = 32'hA; mdu_pc = 32'h8000;
    tick();
    mdu_wa = 5'd11; mdu_wd = 32'hB; mdu_pc = 32'h8004;
    total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL full_ready_b got=%b exp=1", mdu_ready); end
    tick();
    mdu_wa = 5'd12; mdu_wd = 32'hC; mdu_pc = 32'h8008;
    total++; if (mdu_ready !== 1'b0) begin bad++; $display("FAIL full_ready_low got=%b exp=0", mdu_ready); end
    total++; if (mdu_busy_mask !== 32'h0000_0C00) begin bad++; $display("FAIL full_mask got=%h exp=00000c00", mdu_busy_mask); end
    for (int i = 0; i < 24; i++) begin
      accepted = mdu_valid && mdu_ready;
      tick();
      if (accepted) begin
        mdu_valid = 1'b0;
        accept_at = i;
      end
      if (grf_we && grf_wa != 5'd5) seen.push_back(grf_wd);
    end
    pipe_valid = 1'b0;
    tick();
    total++; if (accept_at !== 4) begin bad++; $display("FAIL full_third_accept got=%0d exp=4", accept_at); end
    total++; if (seen.size() !== 3) begin bad++; $display("FAIL full_retire_count got=%0d exp=3", seen.size()); end
    if (seen.size() == 3) begin
      total++; if ({seen[0], seen[1], seen[2]} !== {32'hA, 32'hB, 32'hC}) begin bad++; $display("FAIL full_order got=%h,%h,%h exp=a,b,c", seen[0], seen[1], seen[2]); end
    end
    tick();
    total++; if (mdu_busy_mask !== 32'h0) begin bad++; $display("FAIL full_mask_clear got=%h exp=0", mdu_busy_mask); end
  endtask

  task automatic test_zero_writes();
    pipe_valid = 1'b1; pipe_wa = 5'd0; pipe_wd = 32'h77; pipe_pc = 32'h9000;
    total++; if (pipe_ready !== 1'b1) begin bad++; $display("FAIL zero_pipe_ready got=%b exp=1", pipe_ready); end
    tick();
    pipe_valid = 1'b0;
    total++; if (grf_we !== 1'b0) begin bad++; $display("FAIL zero_pipe_we got=%b exp=0", grf_we); end
    mdu_valid = 1'b1; mdu_wa = 5'd0; mdu_wd = 32'h88; mdu_pc = 32'h9004;
    total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL zero_mdu_ready got=%b exp=1", mdu_ready); end
    tick();
    mdu_valid = 1'b0;
    total++; if (mdu_busy_mask !== 32'h0) begin bad++; $display("FAIL zero_mask_fifo got=%h exp=0", mdu_busy_mask); end
    total++; if (pipe_ready !== 1'b0) begin bad++; $display("FAIL zero_mdu_pending got=%b exp=0", pipe_ready); end
    tick();
    total++; if (grf_we !== 1'b0 || mdu_busy_mask !== 32'h0) begin bad++; $display("FAIL zero_mdu_out got=%b/%h exp=0/0", grf_we, mdu_busy_mask); end
    total++; if (pipe_ready !== 1'b1) begin bad++; $display("FAIL zero_drained got=%b exp=1", pipe_ready); end
  endtask

  task automatic test_reset_mid();
    pipe_valid = 1'b1; pipe_wa = 5'd6; pipe_wd = 32'h300; pipe_pc = 32'hA000;
    mdu_valid = 1'b1;  mdu_wa = 5'd13; mdu_wd = 32'hD; mdu_pc = 32'hB000;
    tick();
    mdu_wa = 5'd14; mdu_wd = 32'hE;
    tick();
    mdu_valid = 1'b0;
    total++; if (mdu_busy_mask !== 32'h0000_6000) begin bad++; $display("FAIL rmid_mask_before got=%h exp=00006000", mdu_busy_mask); end
    total++; if (grf_we !== 1'b1 || mdu_ready !== 1'b0) begin bad++; $display("FAIL rmid_before got=%b/%b exp=1/0", grf_we, mdu_ready); end
    #1 reset = 1'b0;
    #1;
    total++; if (grf_we !== 1'b0) begin bad++; $display("FAIL rmid_we_drop got=%b exp=0", grf_we); end
    total++; if (mdu_busy_mask !== 32'h0) begin bad++; $display("FAIL rmid_mask_drop got=%h exp=0", mdu_busy_mask); end
    total++; if (mdu_ready !== 1'b1 || pipe_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b/%b exp=1/1", mdu_ready, pipe_ready); end
    pipe_valid = 1'b0;
    #1 reset = 1'b1;
    tick();
    total++; if (grf_we !== 1'b0 || mdu_busy_mask !== 32'h0) begin bad++; $display("FAIL rmid_after got=%b/%h exp=0/0", grf_we, mdu_busy_mask); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_pipe_write();
    test_mdu_single();
    test_starvation();
    test_fifo_full();
    test_zero_writes();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
